// File: rtl/mem_stage_ld_pkg.sv
// Shared definitions for the load/store MEM stage: load opcodes, FSM states
// and the bit positions of fields on the EX->MEM and MEM->WB buses.
package mem_stage_ld_pkg;

    localparam logic [2:0] LD_B    = 3'b000;
    localparam logic [2:0] LD_H    = 3'b001;
    localparam logic [2:0] LD_W    = 3'b010;
    localparam logic [2:0] LD_D    = 3'b011;
    localparam logic [2:0] LD_BU   = 3'b100;
    localparam logic [2:0] LD_HU   = 3'b101;
    localparam logic [2:0] LD_WU   = 3'b110;
    localparam logic [2:0] LD_FULL = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } ms_state_e;

    // Control bits sit above {dest, alu_result, pc}; these are relative to that base.
    localparam int ES_GR_WE        = 0;
    localparam int ES_RES_FROM_MEM = 1;
    localparam int ES_MEM_REQ      = 2;
    localparam int ES_LD_OP        = 3;

    function automatic int es_alu_lsb(input int pc_w);
        return pc_w;
    endfunction

    function automatic int es_dest_lsb(input int data_w, input int pc_w);
        return pc_w + data_w;
    endfunction

    function automatic int es_ctrl_lsb(input int dest_w, input int data_w, input int pc_w);
        return pc_w + data_w + dest_w;
    endfunction

    function automatic int ws_result_lsb(input int pc_w);
        return pc_w;
    endfunction

    function automatic int ws_dest_lsb(input int data_w, input int pc_w);
        return pc_w + data_w;
    endfunction

    function automatic int ws_gr_we_bit(input int dest_w, input int data_w, input int pc_w);
        return pc_w + data_w + dest_w;
    endfunction

endpackage

// File: rtl/mem_stage_ld_load_align.sv
// Byte-lane alignment and sign/zero extension of a raw data-sram read word.
module load_align
    import mem_stage_ld_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             rdata,
    input  logic [$clog2(DATA_W/8)-1:0]   offset,
    input  logic [2:0]                    ld_op,
    output logic [DATA_W-1:0]             result
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] sext8;
    logic [DATA_W-1:0] sext16;
    logic [DATA_W-1:0] zext8;
    logic [DATA_W-1:0] zext16;
    logic [DATA_W-1:0] sext32;
    logic [DATA_W-1:0] zext32;

    assign shifted = rdata >> {offset, 3'b000};
    assign sext8   = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
    assign sext16  = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
    assign zext8   = {{(DATA_W-8){1'b0}}, shifted[7:0]};
    assign zext16  = {{(DATA_W-16){1'b0}}, shifted[15:0]};

    // On a 32-bit datapath a word already fills the result, so W/WU/D collapse.
    generate
        if (DATA_W > 32) begin : g_wide
            assign sext32 = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            assign zext32 = {{(DATA_W-32){1'b0}}, shifted[31:0]};
        end else begin : g_narrow
            assign sext32 = shifted;
            assign zext32 = shifted;
        end
    endgenerate

    always_comb begin
        result = shifted;
        case (ld_op)
            LD_B:    result = sext8;
            LD_H:    result = sext16;
            LD_W:    result = sext32;
            LD_D:    result = (DATA_W > 32) ? shifted : sext32;
            LD_BU:   result = zext8;
            LD_HU:   result = zext16;
            LD_WU:   result = zext32;
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_ld.sv
// MEM stage: holds one instruction, waits for its data-sram response and
// discards stale responses left over from flushed requests.
module mem_stage_ld
    import mem_stage_ld_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int DEST_W  = 5,
    parameter int MAX_OUT = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ws_allowin,
    output logic                               ms_allowin,
    input  logic                               es_to_ms_valid,
    input  logic [6+DEST_W+DATA_W+PC_W-1:0]    es_to_ms_bus,
    output logic                               ms_to_ws_valid,
    output logic [1+DEST_W+DATA_W+PC_W-1:0]    ms_to_ws_bus,
    input  logic                               flush,
    input  logic                               es_req_inflight,
    input  logic                               data_sram_data_ok,
    input  logic [DATA_W-1:0]                  data_sram_rdata,
    output logic [2+DEST_W+DATA_W-1:0]         ms_fwd_bus
);

    localparam int OFS_W    = $clog2(DATA_W/8);
    localparam int CNT_W    = $clog2(MAX_OUT+1);
    localparam int ALU_LSB  = es_alu_lsb(PC_W);
    localparam int DEST_LSB = es_dest_lsb(DATA_W, PC_W);
    localparam int CTRL_LSB = es_ctrl_lsb(DEST_W, DATA_W, PC_W);

    ms_state_e          state;
    logic [CNT_W-1:0]   disc_cnt;
    logic [CNT_W-1:0]   disc_next;
    int                 disc_sum;

    logic [2:0]         ld_op_r;
    logic               res_from_mem_r;
    logic               gr_we_r;
    logic [DEST_W-1:0]  dest_r;
    logic [DATA_W-1:0]  alu_result_r;
    logic [PC_W-1:0]    pc_r;
    logic [DATA_W-1:0]  rdata_r;

    logic               accept;
    logic               in_mem_req;
    logic               consume;
    logic [DATA_W-1:0]  load_data;
    logic [DATA_W-1:0]  final_result;
    logic               fwd_valid;
    logic               ld_pending;

    assign in_mem_req = es_to_ms_bus[CTRL_LSB + ES_MEM_REQ];
    assign ms_allowin = !flush && ((state == ST_EMPTY) || ((state == ST_DONE) && ws_allowin));
    assign accept     = es_to_ms_valid && ms_allowin;
    assign consume    = (state == ST_WAIT) && (disc_cnt == '0) && data_sram_data_ok;

    // Every data_ok retires one outstanding request, so during a flush it always
    // offsets the requests being abandoned; otherwise only stale ones count down.
    always_comb begin
        disc_sum = int'(disc_cnt);
        if (flush) begin
            disc_sum = disc_sum + int'(state == ST_WAIT) + int'(es_req_inflight);
        end
        if (data_sram_data_ok && (flush || !consume)) begin
            disc_sum = disc_sum - 1;
        end
        if (disc_sum < 0) begin
            disc_sum = 0;
        end else if (disc_sum > MAX_OUT) begin
            disc_sum = MAX_OUT;
        end
        disc_next = CNT_W'(disc_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            disc_cnt <= '0;
        end else begin
            disc_cnt <= disc_next;
            if (flush) begin
                state <= ST_EMPTY;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (accept) state <= in_mem_req ? ST_WAIT : ST_DONE;
                    end
                    ST_WAIT: begin
                        if (consume) state <= ST_DONE;
                    end
                    ST_DONE: begin
                        if (accept)          state <= in_mem_req ? ST_WAIT : ST_DONE;
                        else if (ws_allowin) state <= ST_EMPTY;
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

    // Payload registers carry no reset; they are only observed while state says valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            ld_op_r        <= es_to_ms_bus[CTRL_LSB + ES_LD_OP +: 3];
            res_from_mem_r <= es_to_ms_bus[CTRL_LSB + ES_RES_FROM_MEM];
            gr_we_r        <= es_to_ms_bus[CTRL_LSB + ES_GR_WE];
            dest_r         <= es_to_ms_bus[DEST_LSB +: DEST_W];
            alu_result_r   <= es_to_ms_bus[ALU_LSB +: DATA_W];
            pc_r           <= es_to_ms_bus[PC_W-1:0];
        end
        if (consume) begin
            rdata_r <= data_sram_rdata;
        end
    end

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .rdata  (rdata_r),
        .offset (alu_result_r[OFS_W-1:0]),
        .ld_op  (ld_op_r),
        .result (load_data)
    );

    assign final_result   = res_from_mem_r ? load_data : alu_result_r;
    assign ms_to_ws_valid = (state == ST_DONE) && !flush;
    assign ms_to_ws_bus   = {gr_we_r, dest_r, final_result, pc_r};

    assign fwd_valid  = (state != ST_EMPTY) && gr_we_r;
    assign ld_pending = (state == ST_WAIT) && res_from_mem_r;
    assign ms_fwd_bus = {fwd_valid, ld_pending, dest_r, final_result};

endmodule

// File: tb/tb_mem_stage_ld.sv
// Directed bench for mem_stage_ld: a table of single-instruction vectors plus
// hand-written flush, back-pressure, saturation and reset sequences.
module tb_mem_stage_ld;
    import mem_stage_ld_pkg::*;

    localparam int DATA_W   = 32;
    localparam int PC_W     = 32;
    localparam int DEST_W   = 5;
    localparam int MAX_OUT  = 2;
    localparam int ES_BUS_W = 6 + DEST_W + DATA_W + PC_W;
    localparam int WS_BUS_W = 1 + DEST_W + DATA_W + PC_W;
    localparam int FWD_W    = 2 + DEST_W + DATA_W;
    localparam int NVEC     = 13;

    logic                clk = 1'b0;
    logic                reset;
    logic                ws_allowin;
    logic                ms_allowin;
    logic                es_to_ms_valid;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic                ms_to_ws_valid;
    logic [WS_BUS_W-1:0] ms_to_ws_bus;
    logic                flush;
    logic                es_req_inflight;
    logic                data_sram_data_ok;
    logic [DATA_W-1:0]   data_sram_rdata;
    logic [FWD_W-1:0]    ms_fwd_bus;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0]        op;
        logic              mreq;
        logic              rfm;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
        int                delay;
        logic [DATA_W-1:0] expect_res;
    } vec_t;

    vec_t vecs [NVEC];

    mem_stage_ld #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .DEST_W  (DEST_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .flush             (flush),
        .es_req_inflight   (es_req_inflight),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [ES_BUS_W-1:0] make_es(input logic [2:0] op, input logic mreq,
                                                     input logic rfm, input logic we,
                                                     input logic [DEST_W-1:0] d,
                                                     input logic [DATA_W-1:0] alu,
                                                     input logic [PC_W-1:0] pc);
        return {op, mreq, rfm, we, d, alu, pc};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge with ms_allowin high; returns at the next negedge.
    task automatic applyStimulus(input logic [ES_BUS_W-1:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
    endtask

    task automatic deliver(input logic [DATA_W-1:0] data);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = data;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
    endtask

    function automatic logic [DATA_W-1:0] res_of(input logic [WS_BUS_W-1:0] b);
        return b[ws_result_lsb(PC_W) +: DATA_W];
    endfunction

    // Gets disc_cnt to two via a flush in WAIT with another request in flight.
    task automatic flushWithInflight();
        applyStimulus(make_es(LD_W, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'h1C00_0200));
        flush = 1'b1;
        es_req_inflight = 1'b1;
        #1;
        checkOutput("flush_allowin", 128'(ms_allowin), 128'(1'b0));
        @(negedge clk);
        flush = 1'b0;
        es_req_inflight = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{LD_W,    1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000, 0, 32'h0000_1234};
        vecs[1]  = '{LD_B,    1'b1, 1'b1, 32'h0000_2003, 32'h80FF_FF00, 2, 32'hFFFF_FF80};
        vecs[2]  = '{LD_HU,   1'b1, 1'b1, 32'h0000_2002, 32'h8001_5A5A, 0, 32'h0000_8001};
        vecs[3]  = '{LD_H,    1'b1, 1'b1, 32'h0000_2000, 32'h1234_8765, 1, 32'hFFFF_8765};
        vecs[4]  = '{LD_BU,   1'b1, 1'b1, 32'h0000_2001, 32'h1234_F056, 0, 32'h0000_00F0};
        vecs[5]  = '{LD_W,    1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_BABE, 0, 32'hCAFE_BABE};
        vecs[6]  = '{LD_D,    1'b1, 1'b1, 32'h0000_2000, 32'h8765_4321, 0, 32'h8765_4321};
        vecs[7]  = '{LD_WU,   1'b1, 1'b1, 32'h0000_2000, 32'hF000_000F, 0, 32'hF000_000F};
        vecs[8]  = '{LD_B,    1'b1, 1'b1, 32'h0000_2001, 32'h0000_7F00, 0, 32'h0000_007F};
        vecs[9]  = '{LD_H,    1'b1, 1'b1, 32'h0000_2002, 32'h7FFF_0000, 0, 32'h0000_7FFF};
        vecs[10] = '{LD_FULL, 1'b1, 1'b1, 32'h0000_2000, 32'h1357_9BDF, 0, 32'h1357_9BDF};
        vecs[11] = '{LD_W,    1'b1, 1'b0, 32'h1000_0008, 32'hFFFF_FFFF, 1, 32'h1000_0008};
        vecs[12] = '{LD_B,    1'b1, 1'b1, 32'h0000_2000, 32'h1111_1181, 0, 32'hFFFF_FF81};

        reset = 1'b1;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        flush = 1'b0;
        es_req_inflight = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_allowin", 128'(ms_allowin), 128'(1'b1));
        checkOutput("reset_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        checkOutput("reset_fwd_valid", 128'(ms_fwd_bus[FWD_W-1]), 128'(1'b0));
        checkOutput("reset_disc_cnt", 128'(dut.disc_cnt), 128'(0));
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            logic [DEST_W-1:0] d;
            logic [PC_W-1:0]   pc;
            d  = DEST_W'(i + 1);
            pc = 32'h1C00_0000 + 32'(i * 4);
            checkOutput("vec_allowin", 128'(ms_allowin), 128'(1'b1));
            applyStimulus(make_es(vecs[i].op, vecs[i].mreq, vecs[i].rfm, 1'b1, d, vecs[i].alu, pc));
            if (vecs[i].mreq) begin
                checkOutput("vec_wait_valid", 128'(ms_to_ws_valid), 128'(1'b0));
                checkOutput("vec_wait_fwd_valid", 128'(ms_fwd_bus[FWD_W-1]), 128'(1'b1));
                for (int k = 0; k <= vecs[i].delay; k++) begin
                    checkOutput("vec_ld_pending", 128'(ms_fwd_bus[FWD_W-2]), 128'(vecs[i].rfm));
                    if (k < vecs[i].delay) begin
                        @(negedge clk);
                        #1;
                    end
                end
                deliver(vecs[i].rdata);
            end
            checkOutput("vec_done_valid", 128'(ms_to_ws_valid), 128'(1'b1));
            checkOutput("vec_ws_bus", 128'(ms_to_ws_bus), 128'({1'b1, d, vecs[i].expect_res, pc}));
            checkOutput("vec_done_pending", 128'(ms_fwd_bus[FWD_W-2]), 128'(1'b0));
            @(negedge clk);
            #1;
            checkOutput("vec_drained", 128'(ms_to_ws_valid), 128'(1'b0));
        end

        // Stale responses are dropped before the new load's own data.
        flushWithInflight();
        checkOutput("flush_disc_cnt", 128'(dut.disc_cnt), 128'(2));
        checkOutput("flush_empty_fwd", 128'(ms_fwd_bus[FWD_W-1]), 128'(1'b0));
        deliver(32'h1111_1111);
        checkOutput("disc_empty_dec", 128'(dut.disc_cnt), 128'(1));
        applyStimulus(make_es(LD_W, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_2000, 32'h1C00_0100));
        deliver(32'h2222_2222);
        checkOutput("disc_wait_ignored", 128'(ms_fwd_bus[FWD_W-2]), 128'(1'b1));
        checkOutput("disc_wait_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        checkOutput("disc_wait_cnt", 128'(dut.disc_cnt), 128'(0));
        deliver(32'h3333_3333);
        checkOutput("third_load_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        checkOutput("third_load_result", 128'(res_of(ms_to_ws_bus)), 128'(32'h3333_3333));
        @(negedge clk);
        #1;

        // Saturation at MAX_OUT, then drain with responses while EMPTY.
        flushWithInflight();
        flushWithInflight();
        checkOutput("disc_saturate", 128'(dut.disc_cnt), 128'(MAX_OUT));
        deliver(32'h4444_4444);
        deliver(32'h5555_5555);
        deliver(32'h6666_6666);
        checkOutput("disc_floor", 128'(dut.disc_cnt), 128'(0));

        // Flush while DONE hides the result and empties the stage.
        applyStimulus(make_es(LD_W, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0777, 32'h1C00_0300));
        ws_allowin = 1'b0;
        flush = 1'b1;
        #1;
        checkOutput("flush_done_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        @(negedge clk);
        flush = 1'b0;
        ws_allowin = 1'b1;
        #1;
        checkOutput("flush_done_empty", 128'(ms_to_ws_valid), 128'(1'b0));
        checkOutput("flush_done_allowin", 128'(ms_allowin), 128'(1'b1));

        // Back-pressure holds the result, then the waiting op follows with no bubble.
        applyStimulus(make_es(LD_W, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_ABCD, 32'h1C00_0400));
        ws_allowin = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_es(LD_W, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_5555, 32'h1C00_0404);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("bp_allowin", 128'(ms_allowin), 128'(1'b0));
            checkOutput("bp_hold_bus", 128'(ms_to_ws_bus),
                        128'({1'b1, 5'd3, 32'h0000_ABCD, 32'h1C00_0400}));
            @(negedge clk);
        end
        ws_allowin = 1'b1;
        #1;
        checkOutput("bp_release_allowin", 128'(ms_allowin), 128'(1'b1));
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        checkOutput("b2b_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        checkOutput("b2b_bus", 128'(ms_to_ws_bus),
                    128'({1'b1, 5'd4, 32'h0000_5555, 32'h1C00_0404}));
        @(negedge clk);
        #1;

        // Reset mid-WAIT beats flush, drops the data_ok and clears disc_cnt.
        flushWithInflight();
        applyStimulus(make_es(LD_W, 1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_2000, 32'h1C00_0500));
        reset = 1'b1;
        flush = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h7777_7777;
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        checkOutput("rst_wait_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        checkOutput("rst_wait_allowin", 128'(ms_allowin), 128'(1'b1));
        checkOutput("rst_wait_fwd", 128'(ms_fwd_bus[FWD_W-1]), 128'(1'b0));
        checkOutput("rst_wait_disc", 128'(dut.disc_cnt), 128'(0));
        applyStimulus(make_es(LD_H, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_2000, 32'h1C00_0600));
        deliver(32'h0000_8000);
        checkOutput("post_rst_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        checkOutput("post_rst_result", 128'(res_of(ms_to_ws_bus)), 128'(32'hFFFF_8000));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
